// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared constants for the ALU command controller:
//   - WIDTH_DEF : default operand / byte width (result is 2*WIDTH)
//   - IDLE..SEND_HI : controller state encoding (3-bit)
//   - FUN_* : ALU function codes. The controller does not decode them; they
//     are passed through unchanged. The names are shared with models.
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_A    = 3'd1;
  localparam logic [2:0] GET_B    = 3'd2;
  localparam logic [2:0] EXEC     = 3'd3;
  localparam logic [2:0] WAIT_RES = 3'd4;
  localparam logic [2:0] SEND_LO  = 3'd5;
  localparam logic [2:0] SEND_HI  = 3'd6;

  localparam logic [3:0] FUN_ADD   = 4'h0;
  localparam logic [3:0] FUN_SUB   = 4'h1;
  localparam logic [3:0] FUN_MUL   = 4'h2;
  localparam logic [3:0] FUN_DIV   = 4'h3;
  localparam logic [3:0] FUN_AND   = 4'h4;
  localparam logic [3:0] FUN_OR    = 4'h5;
  localparam logic [3:0] FUN_NAND  = 4'h6;
  localparam logic [3:0] FUN_NOR   = 4'h7;
  localparam logic [3:0] FUN_XOR   = 4'h8;
  localparam logic [3:0] FUN_XNOR  = 4'h9;
  localparam logic [3:0] FUN_CMPEQ = 4'hA;
  localparam logic [3:0] FUN_CMPGT = 4'hB;
  localparam logic [3:0] FUN_CMPLT = 4'hC;
  localparam logic [3:0] FUN_SHR   = 4'hD;
  localparam logic [3:0] FUN_SHL   = 4'hE;

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl_if
// Bundles the RX byte input, the ALU command/result pair, the TX byte
// handshake and the status flags of the ALU command controller.
//   master : the controller (drives ALU command, TX byte, status)
//   slave  : the surrounding RX deframer / ALU / TX serializer
// Signals:
//   rx_data/rx_valid          RX byte strobe (no back-pressure)
//   alu_en/alu_fun/alu_a/alu_b  ALU command
//   alu_out/alu_out_valid     ALU result (2*WIDTH)
//   tx_data/tx_valid/tx_ready TX byte handshake
//   busy/frame_err            status
// -----------------------------------------------------------------------------
interface alu_cmd_ctrl_if
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic [WIDTH-1:0]   rx_data;
  logic               rx_valid;
  logic               alu_en;
  logic [3:0]         alu_fun;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [2*WIDTH-1:0] alu_out;
  logic               alu_out_valid;
  logic [WIDTH-1:0]   tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic               frame_err;

  modport master (
    input  rx_data, rx_valid, alu_out, alu_out_valid, tx_ready,
    output alu_en, alu_fun, alu_a, alu_b, tx_data, tx_valid, busy, frame_err
  );

  modport slave (
    output rx_data, rx_valid, alu_out, alu_out_valid, tx_ready,
    input  alu_en, alu_fun, alu_a, alu_b, tx_data, tx_valid, busy, frame_err
  );

endinterface

// File: rtl/alu_res_serializer.sv
// -----------------------------------------------------------------------------
// alu_res_serializer
// Holds the 2*WIDTH result register and presents it to the TX path as two
// bytes, LSB first. The controller says which half to present (send_lo /
// send_hi); the serializer reports acceptance of the MSB byte with done.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load, load_data   capture a new result
//   send_lo, send_hi  present the low / high half on tx_data
//   tx_ready          TX acceptance
//   tx_valid, tx_data TX byte
//   done              high in the cycle the high byte is accepted
// -----------------------------------------------------------------------------
module alu_res_serializer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2*WIDTH-1:0] load_data,
  input  logic               send_lo,
  input  logic               send_hi,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [WIDTH-1:0]   tx_data,
  output logic               done
);

  logic [2*WIDTH-1:0] res_q, res_d;

  always_comb begin
    res_d = res_q;
    if (load) res_d = load_data;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  // Valid depends only on registered state, never on tx_ready; the data is
  // muxed from a register that cannot change while a byte is being offered.
  assign tx_valid = send_lo | send_hi;
  assign tx_data  = send_hi ? res_q[2*WIDTH-1:WIDTH] :
                    send_lo ? res_q[WIDTH-1:0]       : '0;
  assign done     = send_hi & tx_ready;

endmodule

// File: rtl/alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl
// Initiator side of the ALU command interface. Parses {FUN, A, B} frames from
// the RX byte stream, issues a one-cycle ALU_EN command, captures the 2*WIDTH
// result and returns it to TX as two bytes, LSB first.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  alu_cmd_ctrl_if.master (RX bytes, ALU command/result, TX bytes,
//        busy, frame_err)
// Parameters:
//   WIDTH     operand / byte width (must exceed 4)
//   WDOG_CYC  result timeout in cycles, used only when ALU_WDOG_EN is defined
// Configuration macro:
//   ALU_WDOG_EN  when defined, a missing ALU result after WDOG_CYC cycles in
//                WAIT_RES yields RES = all ones and a frame_err pulse.
// -----------------------------------------------------------------------------
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int WDOG_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  alu_cmd_ctrl_if.master bus
);

  logic [2:0]         state_q, state_d;
  logic [3:0]         fun_q, fun_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               capture;
  logic [2*WIDTH-1:0] capture_data;
  logic               frame_err;
  logic               ser_done;
  logic               cmd_ok;

`ifdef ALU_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] wdog_q, wdog_d;
`endif

  // A command byte carries the function code in its low nibble only.
  assign cmd_ok = (bus.rx_data[WIDTH-1:4] == '0);

  // NOTE: every signal gets its default before the case so no path leaves a
  // value unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d      = state_q;
    fun_d        = fun_q;
    a_d          = a_q;
    b_d          = b_q;
    capture      = 1'b0;
    capture_data = bus.alu_out;
    frame_err    = 1'b0;
`ifdef ALU_WDOG_EN
    wdog_d       = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          if (cmd_ok) begin
            fun_d   = bus.rx_data[3:0];
            state_d = GET_A;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      GET_A: begin
        if (bus.rx_valid) begin
          a_d     = bus.rx_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (bus.rx_valid) begin
          b_d     = bus.rx_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = WAIT_RES;
`ifdef ALU_WDOG_EN
        wdog_d  = '0;
`endif
      end
      WAIT_RES: begin
        if (bus.alu_out_valid) begin
          capture = 1'b1;
          state_d = SEND_LO;
        end
`ifdef ALU_WDOG_EN
        else if (wdog_q == WDW'(WDOG_CYC - 1)) begin
          capture      = 1'b1;
          capture_data = '1;
          frame_err    = 1'b1;
          state_d      = SEND_LO;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      SEND_LO: if (bus.tx_ready) state_d = SEND_HI;
      SEND_HI: if (ser_done)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand registers are reset too, so ALU_FUN/A/B read 0 after reset
  // instead of leaking the aborted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fun_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

`ifdef ALU_WDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`endif

  alu_res_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (capture_data),
    .send_lo   (state_q == SEND_LO),
    .send_hi   (state_q == SEND_HI),
    .tx_ready  (bus.tx_ready),
    .tx_valid  (bus.tx_valid),
    .tx_data   (bus.tx_data),
    .done      (ser_done)
  );

  assign bus.alu_en    = (state_q == EXEC);
  assign bus.alu_fun   = fun_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_ctrl
// Drives command frames into alu_cmd_ctrl, answers ALU commands from a
// behavioural ALU and compares the returned TX bytes against results computed
// from the bytes that were sent. Inputs are driven and outputs sampled 1 ns
// after the falling clock edge.
// Define ALU_WDOG_EN for both bench and RTL to exercise the result timeout.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W    = 8;
  localparam int WDOG = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_ctrl_if #(.WIDTH(W)) bus ();

  alu_cmd_ctrl #(.WIDTH(W), .WDOG_CYC(WDOG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit alu_mute    = 1'b0;
  bit pend        = 1'b0;
  logic [15:0] pend_val;

  function automatic logic [15:0] alu_ref(input logic [3:0] f,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    logic [15:0] x;
    logic [15:0] y;
    x = {8'h00, a};
    y = {8'h00, b};
    case (f)
      FUN_ADD:   return x + y;
      FUN_SUB:   return x - y;
      FUN_MUL:   return x * y;
      FUN_DIV:   return (b == 8'h00) ? 16'hFFFF : x / y;
      FUN_AND:   return x & y;
      FUN_OR:    return x | y;
      FUN_NAND:  return ~(x & y);
      FUN_NOR:   return ~(x | y);
      FUN_XOR:   return x ^ y;
      FUN_XNOR:  return ~(x ^ y);
      FUN_CMPEQ: return {15'd0, a == b};
      FUN_CMPGT: return {15'd0, a > b};
      FUN_CMPLT: return {15'd0, a < b};
      FUN_SHR:   return x >> 1;
      FUN_SHL:   return x << 1;
      default:   return {a, b};
    endcase
  endfunction

  // Behavioural ALU: one-cycle latency, result valid for one cycle, then 0.
  always @(negedge clk) begin
    bus.alu_out_valid = 1'b0;
    bus.alu_out       = '0;
    if (pend) begin
      bus.alu_out_valid = 1'b1;
      bus.alu_out       = pend_val;
      pend              = 1'b0;
    end
    if (bus.alu_en === 1'b1 && !alu_mute) begin
      pend     = 1'b1;
      pend_val = alu_ref(bus.alu_fun, bus.alu_a, bus.alu_b);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.tx_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({bus.alu_en, bus.alu_fun, bus.alu_a, bus.alu_b, bus.tx_data,
         bus.tx_valid, bus.busy, bus.frame_err} !== '0) begin
      miscompares++;
      $display("FAIL %s: en=%b fun=%h a=%h b=%h txd=%h txv=%b busy=%b ferr=%b, all must be 0",
               name, bus.alu_en, bus.alu_fun, bus.alu_a, bus.alu_b, bus.tx_data,
               bus.tx_valid, bus.busy, bus.frame_err);
    end
  endtask

  // Sends one frame and checks the command, latency, TX bytes and return to
  // idle. stall holds TX_READY low on the first byte; inject sends stray RX
  // bytes 77/88 while the first byte is stalled.
  task automatic run_frame(input logic [7:0] f, input logic [7:0] a,
                           input logic [7:0] b, input int stall, input bit inject);
    logic [15:0] exp;
    logic [7:0]  eb [2];
    bit          ok;
    exp   = alu_mute ? 16'hFFFF : alu_ref(f[3:0], a, b);
    eb[0] = exp[7:0];
    eb[1] = exp[15:8];

    bus.rx_data = f; bus.rx_valid = 1'b1; tick();
    bus.rx_data = a; tick();
    bus.rx_data = b; tick();
    bus.rx_valid = 1'b0; bus.rx_data = '0;

    vectors++;
    if (bus.alu_en !== 1'b1 || bus.alu_fun !== f[3:0] || bus.alu_a !== a || bus.alu_b !== b) begin
      miscompares++;
      $display("FAIL exec_cmd: en=%b fun=%h a=%h b=%h, want en=1 fun=%h a=%h b=%h",
               bus.alu_en, bus.alu_fun, bus.alu_a, bus.alu_b, f[3:0], a, b);
    end
    tick();
    vectors++;
    if (bus.alu_en !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL alu_en_pulse: en=%b busy=%b, want en=0 busy=1", bus.alu_en, bus.busy);
    end

    if (!alu_mute) begin
      tick();
      vectors++;
      if (bus.tx_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL result_latency: tx_valid=%b 3 cycles after last byte, want 1", bus.tx_valid);
      end
    end
`ifdef ALU_WDOG_EN
    else begin
      for (int c = 1; c <= WDOG; c++) begin
        vectors++;
        if (bus.frame_err !== (c == WDOG) || bus.tx_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL wdog_cycle%0d: frame_err=%b tx_valid=%b, want frame_err=%b tx_valid=0",
                   c, bus.frame_err, bus.tx_valid, (c == WDOG));
        end
        if (c < WDOG) tick();
      end
      tick();
    end
`endif

    for (int k = 0; k < 2; k++) begin
      wait_tx(ok);
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_timeout: byte %0d never offered, want tx_valid=1", k);
        bus.tx_ready = 1'b0;
        return;
      end
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          bus.tx_ready = 1'b0;
          if (inject && s < 2) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = (s == 0) ? 8'h77 : 8'h88;
          end
          #1;
          vectors++;
          if (bus.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_drop_err: frame_err=%b on stray byte, want 0", bus.frame_err);
          end
          tick();
          bus.rx_valid = 1'b0;
          bus.rx_data  = '0;
          vectors++;
          if (bus.tx_valid !== 1'b1 || bus.tx_data !== eb[0]) begin
            miscompares++;
            $display("FAIL tx_hold: tx_valid=%b tx_data=%h, want 1 %h",
                     bus.tx_valid, bus.tx_data, eb[0]);
          end
        end
      end
      vectors++;
      if (bus.tx_data !== eb[k]) begin
        miscompares++;
        $display("FAIL tx_byte%0d: got %h want %h (fun=%h a=%h b=%h)", k, bus.tx_data, eb[k], f, a, b);
      end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
    end

    vectors++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_end: tx_valid=%b busy=%b, want 0 0", bus.tx_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b0;
    tick(); tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    tick();
    check_all_zero("after_reset");
  endtask

  task automatic test_add();
    run_frame(8'h00, 8'h05, 8'h03, 0, 1'b0);
  endtask

  task automatic test_mul_stall();
    run_frame(8'h02, 8'hFF, 8'hFF, 4, 1'b0);
  endtask

  task automatic test_frame_err();
    bus.rx_data = 8'h35; bus.rx_valid = 1'b1;
    #1;
    vectors++;
    if (bus.frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_err_pulse: got %b want 1", bus.frame_err);
    end
    tick();
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    #1;
    vectors++;
    if (bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_err_idle: frame_err=%b busy=%b, want 0 0", bus.frame_err, bus.busy);
    end
    run_frame(8'h01, 8'h09, 8'h04, 0, 1'b0);
  endtask

  task automatic test_rx_drop();
    run_frame(8'h08, 8'h5A, 8'hC3, 3, 1'b1);
    run_frame(8'h00, 8'h10, 8'h20, 0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    bus.rx_data = 8'h02; bus.rx_valid = 1'b1; tick();
    bus.rx_data = 8'h44; tick();
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    rst = 1'b1;
    #1;
    check_all_zero("reset_midframe");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle: tx_valid=%b busy=%b, want 0 0", bus.tx_valid, bus.busy);
      end
    end
    run_frame(8'h02, 8'h07, 8'h06, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] bad;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bad = {4'($urandom_range(1, 15)), 4'($urandom)};
        bus.rx_data = bad; bus.rx_valid = 1'b1;
        #1;
        vectors++;
        if (bus.frame_err !== 1'b1) begin
          miscompares++;
          $display("FAIL rand_reject: byte %h frame_err=%b, want 1", bad, bus.frame_err);
        end
        tick();
        bus.rx_valid = 1'b0; bus.rx_data = '0;
      end
      run_frame({4'h0, 4'($urandom)}, 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      run_frame({4'h0, 4'(n * 5)}, 8'(8'h31 * n), 8'(8'hF0 - n), 0, 1'b0);
  endtask

`ifdef ALU_WDOG_EN
  task automatic test_wdog();
    alu_mute = 1'b1;
    run_frame(8'h00, 8'h12, 8'h34, 0, 1'b0);
    alu_mute = 1'b0;
    run_frame(8'h00, 8'h01, 8'h01, 0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_mul_stall();
    test_frame_err();
    test_rx_drop();
    test_reset_midframe();
`ifdef ALU_WDOG_EN
    test_wdog();
`endif
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
